// File: rtl/lsu_wb_stage.sv
// lsu_wb_stage: dual-slot load/store and writeback stage.
// One dmem access per cycle; a bundle with two memory ops takes two cycles.
module lsu_wb_stage #(
  parameter int PC_WIDTH         = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int RF_DEPTH_BIT     = 5,
  parameter int SUPER_SCALAR_NUM = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PC_WIDTH-1:0]     exu_lsu_pc         [SUPER_SCALAR_NUM-1:0],
  input  logic                    exu_lsu_pipe_vld   [SUPER_SCALAR_NUM-1:0],
  input  logic                    exu_lsu_wen        [SUPER_SCALAR_NUM-1:0],
  input  logic [RF_DEPTH_BIT-1:0] exu_lsu_rd         [SUPER_SCALAR_NUM-1:0],
  input  logic [DATA_WIDTH-1:0]   exu_lsu_result     [SUPER_SCALAR_NUM-1:0],
  input  logic                    exu_lsu_is_load    [SUPER_SCALAR_NUM-1:0],
  input  logic                    exu_lsu_is_store   [SUPER_SCALAR_NUM-1:0],
  input  logic [2:0]              exu_lsu_funct3     [SUPER_SCALAR_NUM-1:0],
  input  logic [DATA_WIDTH-1:0]   exu_lsu_store_data [SUPER_SCALAR_NUM-1:0],
  output logic                    lsu_exu_stall,
  output logic                    lsu_dmem_en,
  output logic                    lsu_dmem_we,
  output logic [31:0]             lsu_dmem_addr,
  output logic [31:0]             lsu_dmem_wdata,
  output logic [3:0]              lsu_dmem_wstrb,
  input  logic [31:0]             dmem_lsu_rdata,
  output logic [PC_WIDTH-1:0]     lsu_rf_pc          [SUPER_SCALAR_NUM-1:0],
  output logic                    lsu_rf_pipe_vld    [SUPER_SCALAR_NUM-1:0],
  output logic                    lsu_rf_wen         [SUPER_SCALAR_NUM-1:0],
  output logic [RF_DEPTH_BIT-1:0] lsu_rf_rd          [SUPER_SCALAR_NUM-1:0],
  output logic [DATA_WIDTH-1:0]   lsu_rf_wr_data     [SUPER_SCALAR_NUM-1:0]
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SECOND = 1'b1;

  logic [0:0]            r_state;
  logic                  r_use_hold;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_result [SUPER_SCALAR_NUM-1:0];
  logic                  r_ld     [SUPER_SCALAR_NUM-1:0];
  logic [2:0]            r_f3     [SUPER_SCALAR_NUM-1:0];
  logic [1:0]            r_off    [SUPER_SCALAR_NUM-1:0];

  logic [1:0]            w_mem;
  logic [1:0]            w_cnt;
  logic                  w_two;
  logic                  w_sel;
  logic                  w_issue;
  logic                  w_st;
  logic [1:0]            w_sz;
  logic [DATA_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_sdata;

  function automatic logic [DATA_WIDTH-1:0] fmt(
    input logic [DATA_WIDTH-1:0] d,
    input logic [2:0]            f3,
    input logic [1:0]            off
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> {off, 3'b000});
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  fmt = {{24{b[7]}}, b};
      3'b001:  fmt = {{16{h[15]}}, h};
      3'b100:  fmt = {24'd0, b};
      3'b101:  fmt = {16'd0, h};
      default: fmt = d;
    endcase
  endfunction

  // Count memory ops and pick the slot that owns the port this cycle
  always_comb begin
    w_mem = '0;
    for (int i = 0; i < 2; i++) begin
      w_mem[i] = exu_lsu_pipe_vld[i] &
                 (exu_lsu_is_load[i] | exu_lsu_is_store[i]);
    end
    w_cnt   = {1'b0, w_mem[0]} + {1'b0, w_mem[1]};
    w_two   = (r_state == IDLE) && (w_cnt == 2'd2);
    w_sel   = (r_state == SECOND) || !w_mem[0];
    w_issue = !rst && ((r_state == SECOND) ? w_mem[1]
                                           : (w_cnt != 2'd0));
    lsu_exu_stall = !rst && w_two;
  end

  // Drive the data-memory request for the selected slot
  always_comb begin
    w_addr  = exu_lsu_result[w_sel];
    w_sdata = exu_lsu_store_data[w_sel];
    w_sz    = exu_lsu_funct3[w_sel][1:0];
    w_st    = exu_lsu_is_store[w_sel];
    lsu_dmem_en    = w_issue;
    lsu_dmem_we    = w_issue && w_st;
    lsu_dmem_addr  = {w_addr[31:2], 2'b00};
    lsu_dmem_wdata = '0;
    lsu_dmem_wstrb = '0;
    if (w_issue && w_st) begin
      case (w_sz)
        2'b00: begin
          lsu_dmem_wdata = {4{w_sdata[7:0]}};
          lsu_dmem_wstrb = 4'b0001 << w_addr[1:0];
        end
        2'b01: begin
          lsu_dmem_wdata = {2{w_sdata[15:0]}};
          lsu_dmem_wstrb = 4'b0011 << {w_addr[1], 1'b0};
        end
        default: begin
          lsu_dmem_wdata = w_sdata;
          lsu_dmem_wstrb = 4'hF;
        end
      endcase
    end
  end

  // FSM: a two-op bundle spends one extra cycle in SECOND
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else if (w_two) r_state <= SECOND;
    else r_state <= IDLE;
  end

  // Park formatted slot-0 load data while slot 1 is accessed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold     <= '0;
      r_use_hold <= 1'b0;
    end else begin
      r_use_hold <= (r_state == SECOND);
      if (r_state == SECOND)
        r_hold <= fmt(dmem_lsu_rdata, exu_lsu_funct3[0],
                      exu_lsu_result[0][1:0]);
    end
  end

  // Register the writeback bundle; a stall cycle leaves a bubble
  always_ff @(posedge clk) begin
    for (int i = 0; i < SUPER_SCALAR_NUM; i++) begin
      if (rst || w_two) begin
        lsu_rf_pc[i]       <= '0;
        lsu_rf_pipe_vld[i] <= 1'b0;
        lsu_rf_wen[i]      <= 1'b0;
        lsu_rf_rd[i]       <= '0;
        r_result[i]        <= '0;
        r_ld[i]            <= 1'b0;
        r_f3[i]            <= '0;
        r_off[i]           <= '0;
      end else begin
        lsu_rf_pc[i]       <= exu_lsu_pc[i];
        lsu_rf_pipe_vld[i] <= exu_lsu_pipe_vld[i];
        lsu_rf_wen[i]      <= exu_lsu_wen[i] & exu_lsu_pipe_vld[i] &
                              (exu_lsu_rd[i] != '0);
        lsu_rf_rd[i]       <= exu_lsu_rd[i];
        r_result[i]        <= exu_lsu_result[i];
        r_ld[i]            <= exu_lsu_pipe_vld[i] & exu_lsu_is_load[i] &
                              ~exu_lsu_is_store[i];
        r_f3[i]            <= exu_lsu_funct3[i];
        r_off[i]           <= exu_lsu_result[i][1:0];
      end
    end
  end

  // Load data is formatted straight off the memory read bus
  always_comb begin
    for (int i = 0; i < SUPER_SCALAR_NUM; i++) begin
      lsu_rf_wr_data[i] = r_ld[i] ? fmt(dmem_lsu_rdata, r_f3[i], r_off[i])
                                  : r_result[i];
    end
    if (r_use_hold && r_ld[0]) lsu_rf_wr_data[0] = r_hold;
  end

endmodule

// File: tb/tb_lsu_wb_stage.sv
// tb_lsu_wb_stage: vector table, directed multi-cycle cases and a
// randomized run against a byte-level memory reference model.
module tb_lsu_wb_stage;

  typedef struct {
    logic        vld, wen, ld, st;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] res, sd, pc;
  } slot_t;

  typedef struct {
    slot_t       s0, s1;
    logic [31:0] rdata;
    logic        een;
    logic [1:0]  ewen;
    logic [31:0] ed0, ed1;
  } vec_t;

  typedef struct {
    logic        vld  [2];
    logic        wen  [2];
    logic [4:0]  rd   [2];
    logic [31:0] pc   [2];
    logic [31:0] data [2];
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] pc  [1:0];
  logic        vld [1:0];
  logic        wen [1:0];
  logic [4:0]  rd  [1:0];
  logic [31:0] res [1:0];
  logic        ld  [1:0];
  logic        st  [1:0];
  logic [2:0]  f3  [1:0];
  logic [31:0] sd  [1:0];
  logic        stall, den, dwe;
  logic [31:0] daddr, dwdata, rdata;
  logic [3:0]  dstrb;
  logic [31:0] rf_pc   [1:0];
  logic        rf_vld  [1:0];
  logic        rf_wen  [1:0];
  logic [4:0]  rf_rd   [1:0];
  logic [31:0] rf_data [1:0];

  lsu_wb_stage dut (
    .clk(clk), .rst(rst),
    .exu_lsu_pc(pc), .exu_lsu_pipe_vld(vld),
    .exu_lsu_wen(wen), .exu_lsu_rd(rd),
    .exu_lsu_result(res), .exu_lsu_is_load(ld),
    .exu_lsu_is_store(st), .exu_lsu_funct3(f3),
    .exu_lsu_store_data(sd), .lsu_exu_stall(stall),
    .lsu_dmem_en(den), .lsu_dmem_we(dwe),
    .lsu_dmem_addr(daddr), .lsu_dmem_wdata(dwdata),
    .lsu_dmem_wstrb(dstrb), .dmem_lsu_rdata(rdata),
    .lsu_rf_pc(rf_pc), .lsu_rf_pipe_vld(rf_vld),
    .lsu_rf_wen(rf_wen), .lsu_rf_rd(rf_rd),
    .lsu_rf_wr_data(rf_data)
  );

  int n_chk  = 0;
  int n_fail = 0;

  vec_t        vt [11];
  logic [31:0] dmem   [0:63];
  logic [7:0]  refmem [0:255];
  req_t        exp_req [$];
  wb_t         cur;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic slot_t mk(input logic v, w, l, s,
                               input logic [4:0] r, input logic [2:0] f,
                               input logic [31:0] a, d);
    slot_t x;
    x.vld = v; x.wen = w; x.ld = l; x.st = s;
    x.rd = r; x.f3 = f; x.res = a; x.sd = d;
    x.pc = 32'h8000_0000 + 32'(r) * 4;
    return x;
  endfunction

  function automatic slot_t nop();
    return mk(0, 0, 0, 0, 5'd0, 3'd0, 32'd0, 32'd0);
  endfunction

  task automatic drive(input slot_t a, input slot_t b);
    pc[0] = a.pc;   vld[0] = a.vld; wen[0] = a.wen; rd[0] = a.rd;
    res[0] = a.res; ld[0] = a.ld;   st[0] = a.st;   f3[0] = a.f3;
    sd[0] = a.sd;
    pc[1] = b.pc;   vld[1] = b.vld; wen[1] = b.wen; rd[1] = b.rd;
    res[1] = b.res; ld[1] = b.ld;   st[1] = b.st;   f3[1] = b.f3;
    sd[1] = b.sd;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_load(input int a,
                                           input logic [2:0] f);
    int sz, base;
    longint v;
    sz = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    base = a - (a % sz);
    v = 0;
    for (int k = 0; k < sz; k++)
      v += longint'(refmem[base + k]) << (8 * k);
    if (!f[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
      v -= (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  function automatic slot_t rnd_slot();
    slot_t s;
    int kind;
    s.vld = ($urandom_range(0, 3) != 0);
    kind  = int'($urandom_range(0, 2));
    s.ld  = (kind == 1);
    s.st  = (kind == 2);
    s.rd  = 5'($urandom_range(0, 31));
    s.wen = s.st ? 1'b0 : ($urandom_range(0, 4) != 0);
    s.pc  = $urandom;
    s.sd  = $urandom;
    if (kind == 0) s.res = $urandom;
    else s.res = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 255));
    if (kind == 1) begin
      case ($urandom_range(0, 4))
        0: s.f3 = 3'd0;
        1: s.f3 = 3'd1;
        2: s.f3 = 3'd2;
        3: s.f3 = 3'd4;
        default: s.f3 = 3'd5;
      endcase
    end else begin
      s.f3 = 3'($urandom_range(0, 2));
    end
    return s;
  endfunction

  task automatic tick(input logic exp_stall);
    logic [31:0] resp;
    req_t r;
    #1;
    chk("stall", stall, exp_stall);
    for (int i = 0; i < 2; i++) begin
      chk("rf_vld", rf_vld[i], cur.vld[i]);
      chk("rf_wen", rf_wen[i], cur.wen[i]);
      if (cur.vld[i]) begin
        chk("rf_rd", rf_rd[i], cur.rd[i]);
        chk("rf_pc", rf_pc[i], cur.pc[i]);
        chk("rf_data", rf_data[i], cur.data[i]);
      end
    end
    resp = 32'h0;
    if (den) begin
      if (exp_req.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_req: got addr 0x%08h expected none", daddr);
      end else begin
        r = exp_req.pop_front();
        chk("req_addr", daddr, r.addr);
        chk("req_we", dwe, r.we);
        chk("req_strb", dstrb, r.strb);
        if (r.we) chk("req_wdata", dwdata, r.wdata);
      end
      if (dwe) begin
        for (int l = 0; l < 4; l++)
          if (dstrb[l]) dmem[daddr[7:2]][l*8 +: 8] = dwdata[l*8 +: 8];
      end else begin
        resp = dmem[daddr[7:2]];
      end
    end
    adv();
    rdata = resp;
  endtask

  task automatic run_rand(input slot_t a, input slot_t b);
    slot_t sl [2];
    wb_t   nx;
    wb_t   bub;
    req_t  r;
    int    cnt, sz, base, lo;
    sl[0] = a;
    sl[1] = b;
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      bub.vld[i] = 0; bub.wen[i] = 0; bub.rd[i] = 0;
      bub.pc[i] = 0; bub.data[i] = 0;
      nx.vld[i]  = sl[i].vld;
      nx.wen[i]  = sl[i].wen && sl[i].vld && (sl[i].rd != 0);
      nx.rd[i]   = sl[i].rd;
      nx.pc[i]   = sl[i].pc;
      nx.data[i] = sl[i].res;
      if (sl[i].vld && (sl[i].ld || sl[i].st)) begin
        cnt++;
        lo = int'(sl[i].res[7:0]);
        r.addr = sl[i].res & 32'hFFFF_FFFC;
        r.strb = 4'h0;
        r.wdata = 32'h0;
        if (sl[i].st) begin
          r.we = 1'b1;
          sz = (sl[i].f3[1:0] == 2'd0) ? 1 : (sl[i].f3[1:0] == 2'd1) ? 2 : 4;
          base = lo - (lo % sz);
          for (int k = 0; k < sz; k++) begin
            r.strb[(base + k) % 4] = 1'b1;
            refmem[base + k] = sl[i].sd[k*8 +: 8];
          end
          for (int l = 0; l < 4; l++)
            r.wdata[l*8 +: 8] = sl[i].sd[(l % sz)*8 +: 8];
        end else begin
          r.we = 1'b0;
          nx.data[i] = ref_load(lo, sl[i].f3);
        end
        exp_req.push_back(r);
      end
    end
    drive(a, b);
    if (cnt == 2) begin
      tick(1'b1);
      cur = bub;
      tick(1'b0);
    end else begin
      tick(1'b0);
    end
    cur = nx;
    chk("req_drain", exp_req.size(), 0);
  endtask

  initial begin
    rdata = 32'h0;

    vt[0]  = '{mk(1,1,0,0,5'd1,3'd0,32'd91,0), mk(0,1,0,0,5'd2,3'd0,32'd7,0),
               32'h0, 1'b0, 2'b01, 32'd91, 32'd7};
    vt[1]  = '{mk(1,1,0,0,5'd0,3'd0,32'd5,0), nop(),
               32'h0, 1'b0, 2'b00, 32'd5, 32'd0};
    vt[2]  = '{mk(1,1,1,0,5'd3,3'b000,32'h103,0),
               mk(1,1,0,0,5'd4,3'd0,32'h55,0),
               32'h80FF_0000, 1'b1, 2'b11, 32'hFFFF_FF80, 32'h55};
    vt[3]  = '{mk(1,1,1,0,5'd3,3'b100,32'h103,0), nop(),
               32'h80FF_0000, 1'b1, 2'b01, 32'h0000_0080, 32'h0};
    vt[4]  = '{mk(1,1,1,0,5'd3,3'b101,32'h102,0), nop(),
               32'h8001_0000, 1'b1, 2'b01, 32'h0000_8001, 32'h0};
    vt[5]  = '{mk(1,1,1,0,5'd3,3'b001,32'h102,0), nop(),
               32'h8001_0000, 1'b1, 2'b01, 32'hFFFF_8001, 32'h0};
    vt[6]  = '{mk(1,1,0,0,5'd9,3'd0,32'hA,0),
               mk(1,1,1,0,5'd10,3'b010,32'hC,0),
               32'h1234_5678, 1'b1, 2'b11, 32'hA, 32'h1234_5678};
    vt[7]  = '{nop(), mk(1,1,1,0,5'd11,3'b000,32'h101,0),
               32'h0000_7F00, 1'b1, 2'b10, 32'h0, 32'h7F};
    vt[8]  = '{mk(1,1,1,0,5'd12,3'b010,32'h107,0), nop(),
               32'hCAFE_F00D, 1'b1, 2'b01, 32'hCAFE_F00D, 32'h0};
    vt[9]  = '{mk(1,1,1,0,5'd13,3'b101,32'h101,0), nop(),
               32'hAAAA_5555, 1'b1, 2'b01, 32'h0000_5555, 32'h0};
    vt[10] = '{mk(1,0,0,1,5'd0,3'b010,32'h40,32'h99),
               mk(1,1,0,0,5'd14,3'd0,32'h77,0),
               32'h0, 1'b1, 2'b10, 32'h40, 32'h77};

    // reset with a live two-load bundle on the inputs
    rst = 1'b1;
    drive(mk(1,1,1,0,5'd1,3'd2,32'h40,0), mk(1,1,1,0,5'd2,3'd2,32'h44,0));
    for (int c = 0; c < 2; c++) begin
      adv();
      chk("rst_stall", stall, 0);
      chk("rst_den", den, 0);
      for (int i = 0; i < 2; i++) begin
        chk("rst_vld", rf_vld[i], 0);
        chk("rst_wen", rf_wen[i], 0);
        chk("rst_rd", rf_rd[i], 0);
        chk("rst_pc", rf_pc[i], 0);
        chk("rst_data", rf_data[i], 0);
      end
    end
    rst = 1'b0;
    drive(nop(), nop());
    adv();

    // single-cycle bundles from the table
    for (int k = 0; k < 11; k++) begin
      drive(vt[k].s0, vt[k].s1);
      #1;
      chk("tbl_stall", stall, 0);
      chk("tbl_den", den, vt[k].een);
      adv();
      drive(nop(), nop());
      rdata = vt[k].rdata;
      #1;
      chk("tbl_vld0", rf_vld[0], vt[k].s0.vld);
      chk("tbl_vld1", rf_vld[1], vt[k].s1.vld);
      chk("tbl_wen", {rf_wen[1], rf_wen[0]}, vt[k].ewen);
      chk("tbl_data0", rf_data[0], vt[k].ed0);
      chk("tbl_data1", rf_data[1], vt[k].ed1);
      chk("tbl_rd0", rf_rd[0], vt[k].s0.rd);
      adv();
    end

    // SH then LW in one bundle
    drive(mk(1,0,0,1,5'd0,3'b001,32'h206,32'h1234),
          mk(1,1,1,0,5'd7,3'b010,32'h300,0));
    #1;
    chk("dual_stall_c", stall, 1);
    chk("dual_en_c", den, 1);
    chk("dual_we_c", dwe, 1);
    chk("dual_addr_c", daddr, 32'h204);
    chk("dual_strb_c", dstrb, 4'b1100);
    chk("dual_wdata_c", dwdata, 32'h1234_1234);
    adv();
    #1;
    chk("dual_stall_c1", stall, 0);
    chk("dual_en_c1", den, 1);
    chk("dual_we_c1", dwe, 0);
    chk("dual_addr_c1", daddr, 32'h300);
    chk("dual_strb_c1", dstrb, 0);
    chk("dual_bub0", rf_vld[0], 0);
    chk("dual_bub1", rf_vld[1], 0);
    adv();
    drive(nop(), nop());
    rdata = 32'hDEAD_BEEF;
    #1;
    chk("dual_vld0", rf_vld[0], 1);
    chk("dual_vld1", rf_vld[1], 1);
    chk("dual_wen", {rf_wen[1], rf_wen[0]}, 2'b10);
    chk("dual_data1", rf_data[1], 32'hDEAD_BEEF);
    adv();

    // two loads: slot 0 must come from the hold register
    drive(mk(1,1,1,0,5'd5,3'b000,32'h11,0),
          mk(1,1,1,0,5'd6,3'b101,32'h22,0));
    #1;
    chk("hold_stall", stall, 1);
    chk("hold_addr0", daddr, 32'h10);
    adv();
    rdata = 32'h0000_9900;
    #1;
    chk("hold_stall2", stall, 0);
    chk("hold_addr1", daddr, 32'h20);
    adv();
    drive(nop(), nop());
    rdata = 32'hBEEF_0000;
    #1;
    chk("hold_data0", rf_data[0], 32'hFFFF_FF99);
    chk("hold_data1", rf_data[1], 32'h0000_BEEF);
    chk("hold_wen", {rf_wen[1], rf_wen[0]}, 2'b11);
    adv();

    // reset while in SECOND
    drive(mk(1,1,1,0,5'd1,3'd2,32'h40,0), mk(1,1,1,0,5'd2,3'd2,32'h44,0));
    #1;
    chk("rs2_stall", stall, 1);
    adv();
    rst = 1'b1;
    #1;
    chk("rs2_den", den, 0);
    chk("rs2_stall_r", stall, 0);
    adv();
    rst = 1'b0;
    drive(nop(), nop());
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rs2_vld", rf_vld[i], 0);
      chk("rs2_wen", rf_wen[i], 0);
      chk("rs2_data", rf_data[i], 0);
    end
    adv();
    drive(mk(1,1,1,0,5'd1,3'd2,32'h40,0), mk(1,1,1,0,5'd2,3'd2,32'h44,0));
    #1;
    chk("rs2_idle_stall", stall, 1);
    adv();
    #1;
    chk("rs2_sec_stall", stall, 0);
    chk("rs2_sec_addr", daddr, 32'h44);
    adv();
    drive(nop(), nop());
    adv();
    adv();

    // randomized bundles against the reference model
    for (int w = 0; w < 64; w++) begin
      dmem[w] = $urandom;
      for (int k = 0; k < 4; k++) refmem[w*4 + k] = dmem[w][k*8 +: 8];
    end
    for (int i = 0; i < 2; i++) begin
      cur.vld[i] = 0; cur.wen[i] = 0; cur.rd[i] = 0;
      cur.pc[i] = 0; cur.data[i] = 0;
    end
    rdata = 32'h0;
    for (int n = 0; n < 400; n++) run_rand(rnd_slot(), rnd_slot());
    run_rand(nop(), nop());

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
